muldiv_ctrl: RTL and testbench

Sequencing controller for the M-extension execute resources. Accepts a MUL/DIV class op from the execute stage, based on the decode-pack fields `mul_en`/`mul_opt`, `div_en`/`div_opt` and `op_32`. Holds the pipeline with a stall request while a fixed-latency multiplier or an iterative divider works. Returns one registered 64-bit result with a single-cycle valid pulse. Sits beside the ALU in EXE; the pipeline advances the instruction on the result cycle.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_ctrl_div_iter.sv | 65 ++++++
 rtl/muldiv_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared decode-pack types for the M-extension execute path, plus the
// muldiv sequencing states and a W-form result helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OPT_MUL    = 2'd0,
        OPT_MULH   = 2'd1,
        OPT_MULHSU = 2'd2,
        OPT_MULHU  = 2'd3
    } mul_opt_t;

    typedef enum logic [1:0] {
        OPT_DIV  = 2'd0,
        OPT_DIVU = 2'd1,
        OPT_REM  = 2'd2,
        OPT_REMU = 2'd3
    } div_opt_t;

    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t ST_IDLE = 2'd0;
    localparam muldiv_state_t ST_MUL  = 2'd1;
    localparam muldiv_state_t ST_DIV  = 2'd2;
    localparam muldiv_state_t ST_DONE = 2'd3;

    localparam logic [6:0] DIV_CNT_64 = 7'd64;
    localparam logic [6:0] DIV_CNT_32 = 7'd32;

    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring unsigned radix-2 divider, one quotient bit per cycle.
// Results of the final step are presented combinationally alongside done.
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        is_32,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic [63:0] quotient,
    output logic [63:0] remainder,
    output logic        done
);

    logic [63:0] rem_r;
    logic [63:0] quo_r;
    logic [63:0] dvs_r;
    logic [6:0]  cnt_r;
    logic [64:0] shift_s;
    logic [64:0] diff_s;
    logic [63:0] rem_next_s;
    logic [63:0] quo_next_s;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        shift_s = {rem_r, quo_r[63]};
        diff_s  = shift_s - {1'b0, dvs_r};
        if (!diff_s[64]) begin
            rem_next_s = diff_s[63:0];
            quo_next_s = {quo_r[62:0], 1'b1};
        end else begin
            rem_next_s = shift_s[63:0];
            quo_next_s = {quo_r[62:0], 1'b0};
        end
    end

    // Iteration registers; a W divide is left-aligned so only 32 steps are needed.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            rem_r <= 64'd0;
            quo_r <= 64'd0;
            dvs_r <= 64'd0;
            cnt_r <= 7'd0;
        end else if (start) begin
            rem_r <= 64'd0;
            quo_r <= is_32 ? {dividend[31:0], 32'd0} : dividend;
            dvs_r <= is_32 ? {32'd0, divisor[31:0]} : divisor;
            cnt_r <= is_32 ? DIV_CNT_32 : DIV_CNT_64;
        end else if (cnt_r != 7'd0) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r - 7'd1;
        end else begin
            cnt_r <= 7'd0;
        end
    end

    assign quotient  = quo_next_s;
    assign remainder = rem_next_s;
    assign done      = (cnt_r == 7'd1);

endmodule

// File: rtl/muldiv_ctrl.sv
// MUL/DIV sequencing controller: holds EXE with stall while a fixed-latency
// multiply or an iterative divide runs, then pulses one registered result.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        mul_en,
    input  logic        div_en,
    input  mul_opt_t    mul_opt,
    input  div_opt_t    div_opt,
    input  logic        op_32,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    output logic        stall,
    output logic        out_valid,
    output logic [63:0] out_data
);

    muldiv_state_t state_r;
    logic [6:0]    cnt_r;
    logic [63:0]   out_data_r;
    logic [63:0]   ma_r, mb_r;
    logic          ma_sgn_r, mb_sgn_r, mul_hi_r, op32_r;
    logic          is_rem_r, neg_q_r, neg_r_r;

    logic          accept_s, div_start_s;
    logic          div_signed_s, is_rem_s, div_zero_s, div_ovf_s, special_s;
    logic [63:0]   da_s, db_s, da_abs_s, db_abs_s, most_neg_s, special_res_s;
    logic          mul_w_s, ma_sgn_s, mb_sgn_s;
    logic [63:0]   ma_s;
    logic [129:0]  ma_x_s, mb_x_s, prod_s;
    logic [63:0]   mul_res_s, div_res_s, q_fix_s, r_fix_s;
    logic [63:0]   div_q_s, div_r_s;
    logic          div_done_s;

    assign accept_s    = (state_r == ST_IDLE) && in_valid && (mul_en || div_en) && !flush;
    assign div_start_s = accept_s && !mul_en && !special_s;
    assign out_valid   = (state_r == ST_DONE) && !flush;
    assign stall       = in_valid && (mul_en || div_en) && !out_valid && !flush;
    assign out_data    = out_data_r;

    // Operand preparation and divide special-case detection at accept.
    always_comb begin
        div_signed_s = (div_opt == OPT_DIV) || (div_opt == OPT_REM);
        is_rem_s     = (div_opt == OPT_REM) || (div_opt == OPT_REMU);
        if (op_32) begin
            da_s       = div_signed_s ? sext32(src1) : {32'd0, src1[31:0]};
            db_s       = div_signed_s ? sext32(src2) : {32'd0, src2[31:0]};
            most_neg_s = 64'hFFFF_FFFF_8000_0000;
        end else begin
            da_s       = src1;
            db_s       = src2;
            most_neg_s = 64'h8000_0000_0000_0000;
        end
        div_zero_s = (db_s == 64'd0);
        div_ovf_s  = div_signed_s && (da_s == most_neg_s) && (db_s == 64'hFFFF_FFFF_FFFF_FFFF);
        special_s  = div_zero_s || div_ovf_s;
        if (div_zero_s) begin
            special_res_s = is_rem_s ? da_s : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            special_res_s = is_rem_s ? 64'd0 : da_s;
        end
        if (op_32) begin
            special_res_s = sext32(special_res_s);
        end else begin
            special_res_s = special_res_s;
        end
        da_abs_s = (div_signed_s && da_s[63]) ? (64'd0 - da_s) : da_s;
        db_abs_s = (div_signed_s && db_s[63]) ? (64'd0 - db_s) : db_s;
        mul_w_s  = op_32 && (mul_opt == OPT_MUL);
        ma_s     = mul_w_s ? sext32(src1) : src1;
        ma_sgn_s = (mul_opt != OPT_MULHU);
        mb_sgn_s = (mul_opt == OPT_MUL) || (mul_opt == OPT_MULH);
    end

    // Product and divide fixup from the captured operands.
    always_comb begin
        ma_x_s    = {{66{ma_sgn_r & ma_r[63]}}, ma_r};
        mb_x_s    = {{66{mb_sgn_r & mb_r[63]}}, mb_r};
        prod_s    = ma_x_s * mb_x_s;
        if (mul_hi_r) begin
            mul_res_s = prod_s[127:64];
        end else begin
            mul_res_s = op32_r ? sext32(prod_s[63:0]) : prod_s[63:0];
        end
        q_fix_s   = neg_q_r ? (64'd0 - div_q_s) : div_q_s;
        r_fix_s   = neg_r_r ? (64'd0 - div_r_s) : div_r_s;
        div_res_s = is_rem_r ? r_fix_s : q_fix_s;
        if (op32_r) begin
            div_res_s = sext32(div_res_s);
        end else begin
            div_res_s = div_res_s;
        end
    end

    // Sequencing FSM, operand capture and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 7'd0;
            out_data_r <= 64'd0;
            ma_r       <= 64'd0;
            mb_r       <= 64'd0;
            ma_sgn_r   <= 1'b0;
            mb_sgn_r   <= 1'b0;
            mul_hi_r   <= 1'b0;
            op32_r     <= 1'b0;
            is_rem_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
        end else if (flush) begin
            state_r <= ST_IDLE;
            cnt_r   <= 7'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ma_r     <= ma_s;
                        mb_r     <= src2;
                        ma_sgn_r <= ma_sgn_s;
                        mb_sgn_r <= mb_sgn_s;
                        mul_hi_r <= (mul_opt != OPT_MUL);
                        op32_r   <= mul_en ? mul_w_s : op_32;
                        is_rem_r <= is_rem_s;
                        neg_q_r  <= div_signed_s && (da_s[63] ^ db_s[63]);
                        neg_r_r  <= div_signed_s && da_s[63];
                        if (mul_en) begin
                            state_r <= ST_MUL;
                            cnt_r   <= 7'(MUL_LATENCY);
                        end else if (special_s) begin
                            state_r    <= ST_DONE;
                            cnt_r      <= 7'd0;
                            out_data_r <= special_res_s;
                        end else begin
                            state_r <= ST_DIV;
                            cnt_r   <= op_32 ? DIV_CNT_32 : DIV_CNT_64;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (cnt_r <= 7'd1) begin
                        state_r    <= ST_DONE;
                        cnt_r      <= 7'd0;
                        out_data_r <= mul_res_s;
                    end else begin
                        cnt_r <= cnt_r - 7'd1;
                    end
                end
                ST_DIV: begin
                    if (div_done_s) begin
                        state_r    <= ST_DONE;
                        cnt_r      <= 7'd0;
                        out_data_r <= div_res_s;
                    end else begin
                        cnt_r <= cnt_r - 7'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 7'd0;
                end
            endcase
        end
    end

    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .abort     (flush),
        .is_32     (op_32),
        .dividend  (da_abs_s),
        .divisor   (db_abs_s),
        .quotient  (div_q_s),
        .remainder (div_r_s),
        .done      (div_done_s)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, stall window, results, flush and reset.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, mul_en, div_en, op_32;
    mul_opt_t    mul_opt;
    div_opt_t    div_opt;
    logic [63:0] src1, src2;
    logic        stall, out_valid;
    logic [63:0] out_data;

    int checks = 0;
    int errors = 0;

    muldiv_ctrl #(.MUL_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .mul_en(mul_en), .div_en(div_en), .mul_opt(mul_opt), .div_opt(div_opt),
        .op_32(op_32), .src1(src1), .src2(src2),
        .stall(stall), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at cycle start (#1 after posedge); presents op at T, expects pulse at T+lat.
    task automatic do_op(input string tag, input logic is_mul, input logic [1:0] opt,
                         input logic w, input logic [63:0] a, input logic [63:0] b,
                         input int lat, input logic [63:0] exp);
        int bad = 0;
        in_valid = 1'b1;
        mul_en   = is_mul;
        div_en   = !is_mul;
        mul_opt  = mul_opt_t'(opt);
        div_opt  = div_opt_t'(opt);
        op_32    = w;
        src1     = a;
        src2     = b;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                if (stall !== 1'b1 || out_valid !== 1'b0) bad++;
                @(posedge clk); #1;
                src1 = ~a;
                src2 = ~b;
            end else begin
                check({tag, "_window"}, 64'(bad), 64'd0);
                check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
                check({tag, "_stall"}, {63'd0, stall}, 64'd0);
                check({tag, "_data"}, out_data, exp);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        mul_en   = 1'b0;
        div_en   = 1'b0;
    endtask

    initial begin
        int bad;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mul_en = 1'b0; div_en = 1'b0;
        op_32 = 1'b0; mul_opt = OPT_MUL; div_opt = OPT_DIV; src1 = 64'd0; src2 = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op("div",    1'b0, 2'd0, 1'b0, 64'd100, 64'd7, 65, 64'd14);
        do_op("rem",    1'b0, 2'd2, 1'b0, 64'd100, 64'd7, 65, 64'd2);
        do_op("divu0",  1'b0, 2'd1, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op("remu0",  1'b0, 2'd3, 1'b0, 64'd5, 64'd0, 1, 64'd5);
        do_op("divovf", 1'b0, 2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000);
        do_op("removf", 1'b0, 2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
        do_op("divw",   1'b0, 2'd0, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("remw",   1'b0, 2'd2, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op("divneg", 1'b0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFF2);
        do_op("remneg", 1'b0, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op("mulh",   1'b1, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op("mulhu",  1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3, 64'd1);
        do_op("mulhsu", 1'b1, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op("mul",    1'b1, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op("mulw",   1'b1, 2'd0, 1'b1, 64'h0000_0000_4000_0000, 64'd2, 3, 64'hFFFF_FFFF_8000_0000);

        @(negedge clk);
        check("data_held", out_data, 64'hFFFF_FFFF_8000_0000);
        @(posedge clk); #1;

        // Flush ten cycles into a divide, then a multiply right behind it.
        bad = 0;
        in_valid = 1'b1; div_en = 1'b1; div_opt = OPT_DIV; op_32 = 1'b0;
        src1 = 64'd100; src2 = 64'd7;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (stall !== 1'b1 || out_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_window", 64'(bad), 64'd0);
        check("flush_stall", {63'd0, stall}, 64'd0);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        div_en = 1'b0;
        do_op("mul_after_flush", 1'b1, 2'd0, 1'b0, 64'd3, 64'd5, 3, 64'd15);

        // Reset in the middle of a divide.
        in_valid = 1'b1; div_en = 1'b1; div_opt = OPT_DIV; op_32 = 1'b0;
        src1 = 64'd100; src2 = 64'd7;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0; div_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_data", out_data, 64'd0);
        check("rstmid_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        do_op("div_after_rst", 1'b0, 2'd1, 1'b0, 64'd100, 64'd7, 65, 64'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
